// File: rtl/clk_fail_switch_ctrl_pkg.sv
// Shared types and constants for the clock-failover controller.
//   state_e    : controller states (INIT, ON0, ON1, NO_CLK)
//   FAIL_CNT_W : width of the saturating automatic-failover counter
package clk_fail_switch_ctrl_pkg;

  localparam int FAIL_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ON0    = 2'd1,
    ST_ON1    = 2'd2,
    ST_NO_CLK = 2'd3
  } state_e;

endpackage

// File: rtl/clk_fail_switch_ctrl_if.sv
// Control/status bundle between the failover controller and its environment
// (clock toggles, CSR layer and downstream clock mux).
//   Inputs to the controller : clk0_tgl_i, clk1_tgl_i, manual_en_i,
//                              manual_sel_i, revert_en_i
//   Outputs from controller  : select_o, clk0_ok_o, clk1_ok_o, no_clk_o,
//                              switch_pulse_o, fail_cnt_o, state_o (debug)
// Handshake: there is no valid/ready pair. Every signal is a level that is
// sampled (inputs) or updated (outputs) on each rising edge of clk_i; the
// toggle inputs are asynchronous and are synchronized inside the controller.
// modport slave is the controller, modport master is the environment.
interface clk_fail_switch_ctrl_if;
  import clk_fail_switch_ctrl_pkg::*;

  logic                  clk0_tgl_i;
  logic                  clk1_tgl_i;
  logic                  manual_en_i;
  logic                  manual_sel_i;
  logic                  revert_en_i;
  logic                  select_o;
  logic                  clk0_ok_o;
  logic                  clk1_ok_o;
  logic                  no_clk_o;
  logic                  switch_pulse_o;
  logic [FAIL_CNT_W-1:0] fail_cnt_o;
  state_e                state_o;

  modport master (
    output clk0_tgl_i, clk1_tgl_i, manual_en_i, manual_sel_i, revert_en_i,
    input  select_o, clk0_ok_o, clk1_ok_o, no_clk_o, switch_pulse_o,
           fail_cnt_o, state_o
  );

  modport slave (
    input  clk0_tgl_i, clk1_tgl_i, manual_en_i, manual_sel_i, revert_en_i,
    output select_o, clk0_ok_o, clk1_ok_o, no_clk_o, switch_pulse_o,
           fail_cnt_o, state_o
  );

endinterface

// File: rtl/clk_fail_switch_ctrl_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset.
//   clk_i : destination clock
//   rst_i : asynchronous reset, active high (clears all stages)
//   d_i   : asynchronous input
//   q_o   : synchronized output (last stage)
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] stg_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stg_q <= '0;
    else       stg_q <= {stg_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = stg_q[SYNC_STAGES-1];

endmodule

// File: rtl/clk_fail_switch_ctrl.sv
// Clock-failover controller driving the select of a glitch-free clock mux.
// Measures toggle activity of clk0/clk1 over fixed windows of clk_i, keeps a
// health flag per clock and chooses the mux source (clk0 preferred, optional
// revert, manual override).
//   clk_i : free-running reference clock
//   rst_i : asynchronous reset, active high
//   bus   : clk_fail_switch_ctrl_if.slave (toggles, manual/revert controls,
//           select/health/no_clk/pulse/fail-count status, debug state)
module clk_fail_switch_ctrl
  import clk_fail_switch_ctrl_pkg::*;
#(
  parameter int WIN_CYC     = 1024,
  parameter int MIN_EDGES   = 4,
  parameter int HOLD_WIN    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  clk_fail_switch_ctrl_if.slave bus
);

  localparam int WIN_W = $clog2(WIN_CYC);
  localparam int CNT_W = $clog2(WIN_CYC + 1);
  localparam int EW    = CNT_W + 1;
  localparam int RUN_W = $clog2(HOLD_WIN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIN_W-1:0] win_q;
  logic             win_end;
  logic [1:0]       tgl_raw;
  logic [1:0]       ok_flag;
  logic [1:0]       ok_nxt;

  assign win_end = (win_q == WIN_W'(WIN_CYC - 1));
  assign tgl_raw = {bus.clk1_tgl_i, bus.clk0_tgl_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        win_q <= '0;
    else if (win_end) win_q <= '0;
    else              win_q <= win_q + WIN_W'(1);
  end

  // Per-clock health monitor. The edge detector compares the synchronizer
  // output with one further delay flop, so only settled values are XORed.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic             tgl_s;
    logic             tgl_d;
    logic             edge_det;
    logic [CNT_W-1:0] edge_cnt_q;
    logic [CNT_W:0]   edges_now;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_nxt;
    logic             ok_q;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (tgl_raw[g]),
      .q_o   (tgl_s)
    );

    assign edge_det  = tgl_s ^ tgl_d;
    // The window-end decision includes an edge seen in that last cycle.
    assign edges_now = {1'b0, edge_cnt_q} + {{CNT_W{1'b0}}, edge_det};

    always_comb begin
      run_nxt = '0;
      if (edges_now >= EW'(MIN_EDGES)) begin
        run_nxt = (run_q == RUN_W'(HOLD_WIN)) ? run_q : run_q + RUN_W'(1);
      end
    end

    // Health value being registered this cycle; the FSM decides on it.
    assign ok_nxt[g]  = win_end ? (run_nxt == RUN_W'(HOLD_WIN)) : ok_q;
    assign ok_flag[g] = ok_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        tgl_d      <= 1'b0;
        edge_cnt_q <= '0;
        run_q      <= '0;
        ok_q       <= 1'b0;
      end else begin
        tgl_d <= tgl_s;
        if (win_end) begin
          edge_cnt_q <= '0;
          run_q      <= run_nxt;
          ok_q       <= ok_nxt[g];
        end else if (edge_det && (edge_cnt_q != CNT_MAX)) begin
          edge_cnt_q <= edge_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Source-selection FSM
  state_e                state_q, state_d;
  logic                  sel_q, sel_d;
  logic                  pulse_q;
  logic                  count_fail;
  logic [FAIL_CNT_W-1:0] fail_q;

  always_comb begin
    state_d    = state_q;
    count_fail = 1'b0;
    if (bus.manual_en_i) begin
      // Manual selection overrides any auto result, even at window end.
      state_d = bus.manual_sel_i ? ST_ON1 : ST_ON0;
    end else if (win_end) begin
      case (state_q)
        ST_ON0: begin
          if (!ok_nxt[0]) begin
            state_d    = ok_nxt[1] ? ST_ON1 : ST_NO_CLK;
            count_fail = 1'b1;
          end
        end
        ST_ON1: begin
          // A clk1 failure counts even when revert would also pick clk0.
          if (!ok_nxt[1]) begin
            state_d    = ok_nxt[0] ? ST_ON0 : ST_NO_CLK;
            count_fail = 1'b1;
          end else if (ok_nxt[0] && bus.revert_en_i) begin
            state_d = ST_ON0;
          end
        end
        default: begin
          // INIT and NO_CLK: clk0 wins when both become usable together.
          if (ok_nxt[0])      state_d = ST_ON0;
          else if (ok_nxt[1]) state_d = ST_ON1;
        end
      endcase
    end
  end

  always_comb begin
    case (state_d)
      ST_ON1:    sel_d = 1'b1;
      ST_NO_CLK: sel_d = sel_q;
      default:   sel_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      sel_q   <= 1'b0;
      pulse_q <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pulse_q <= (sel_d != sel_q);
      if (count_fail && (fail_q != '1)) fail_q <= fail_q + FAIL_CNT_W'(1);
    end
  end

  assign bus.select_o       = sel_q;
  assign bus.clk0_ok_o      = ok_flag[0];
  assign bus.clk1_ok_o      = ok_flag[1];
  assign bus.no_clk_o       = (state_q == ST_NO_CLK);
  assign bus.switch_pulse_o = pulse_q;
  assign bus.fail_cnt_o     = fail_q;
  assign bus.state_o        = state_q;

endmodule
